dcache_responder: RTL and testbench

//  Data-side responder of the datapath<->cache protocol: answers dmemREN/dmemWEN from the pipeline

---
 rtl/dcache_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dcache_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-back data cache responder; optional hit counter via HIT_COUNTER_EN
module dcache_responder #(
    parameter int          SETS         = 16,
    parameter logic [31:0] HIT_CNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W:0] PTR_LAST = (IDX_W+1)'(SETS - 1);

    typedef enum logic [2:0] {
        IDLE, WB, FETCH, FLUSH,
`ifdef HIT_COUNTER_EN
        CNT,
`endif
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W:0]              ptr_q, ptr_d;
    logic [SETS-1:0]             valid_q, valid_d;
    logic [SETS-1:0]             dirty_q, dirty_d;
    logic [SETS-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [SETS-1:0][31:0]       data_q, data_d;
    logic                        dren_q, dren_d;
    logic                        dwen_q, dwen_d;
    logic [31:0]                 daddr_q, daddr_d;
    logic [31:0]                 dstore_q, dstore_d;
    logic                        flushed_q, flushed_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] fn_idx;
    logic             req;
    logic             unused_bits;

    assign req_idx = dmemaddr[IDX_W+1:2];
    assign req_tag = dmemaddr[31:IDX_W+2];
    assign f_idx   = ptr_q[IDX_W-1:0];
    assign fn_idx  = ptr_d[IDX_W-1:0];
    assign req     = dmemREN | dmemWEN;

    // Hit is only answered from IDLE, and a same-cycle halt wins over the request
    assign dhit     = (state_q == IDLE) && !halt && req && valid_q[req_idx]
                      && (tag_q[req_idx] == req_tag);
    assign dmemload = dhit ? data_q[req_idx] : 32'h0;

    assign dREN    = dren_q;
    assign dWEN    = dwen_q;
    assign daddr   = daddr_q;
    assign dstore  = dstore_q;
    assign flushed = flushed_q;

`ifdef HIT_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;

    // Saturating count of serviced requests
    always_comb begin
        cnt_d = cnt_q;
        if (dhit && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    // Hit counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= 32'h0;
        else       cnt_q <= cnt_d;
    end

    assign unused_bits = ^dmemaddr[1:0];
`else
    assign unused_bits = ^{dmemaddr[1:0], HIT_CNT_ADDR};
`endif

    // Next state, line updates, and memory-side outputs looked ahead from the next state
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        tag_d     = tag_q;
        data_d    = data_q;
        dren_d    = 1'b0;
        dwen_d    = 1'b0;
        daddr_d   = 32'h0;
        dstore_d  = 32'h0;
        flushed_d = flushed_q;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                    ptr_d   = '0;
                end else if (dhit) begin
                    if (dmemWEN) begin
                        data_d[req_idx]  = dmemstore;
                        dirty_d[req_idx] = 1'b1;
                    end
                end else if (req) begin
                    state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FETCH;
                end
            end
            WB: begin
                if (!dwait) begin
                    dirty_d[req_idx] = 1'b0;
                    state_d          = FETCH;
                end
            end
            FETCH: begin
                if (!dwait) begin
                    data_d[req_idx]  = dload;
                    tag_d[req_idx]   = req_tag;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = IDLE;
                end
            end
            FLUSH: begin
                // A dirty line holds the pointer until memory accepts it; clean lines pass in one cycle
                if (!(valid_q[f_idx] && dirty_q[f_idx] && dwait)) begin
                    dirty_d[f_idx] = 1'b0;
                    ptr_d          = ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
`ifdef HIT_COUNTER_EN
                        state_d = CNT;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef HIT_COUNTER_EN
            CNT: begin
                if (!dwait) state_d = DONE;
            end
`endif
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so drive what the next state needs from its first cycle
        case (state_d)
            WB: begin
                dwen_d   = 1'b1;
                daddr_d  = {tag_q[req_idx], req_idx, 2'b00};
                dstore_d = data_q[req_idx];
            end
            FETCH: begin
                dren_d  = 1'b1;
                daddr_d = {dmemaddr[31:2], 2'b00};
            end
            FLUSH: begin
                if (valid_q[fn_idx] && dirty_q[fn_idx]) begin
                    dwen_d   = 1'b1;
                    daddr_d  = {tag_q[fn_idx], fn_idx, 2'b00};
                    dstore_d = data_q[fn_idx];
                end
            end
`ifdef HIT_COUNTER_EN
            CNT: begin
                dwen_d   = 1'b1;
                daddr_d  = HIT_CNT_ADDR;
                dstore_d = cnt_q;
            end
`endif
            DONE: flushed_d = 1'b1;
            default: ;
        endcase
    end

    // State, cache array and registered memory-side outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            daddr_q   <= 32'h0;
            dstore_q  <= 32'h0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            dren_q    <= dren_d;
            dwen_q    <= dwen_d;
            daddr_q   <= daddr_d;
            dstore_q  <= dstore_d;
            flushed_q <= flushed_d;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - directed self-checking bench for dcache_responder
module tb_dcache_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hit_seen = 0;
    int          ncyc;
    int          nwb;
    int          dren_seen;
    logic [31:0] wb_addr, wb_data;
    logic [31:0] wb_a [4];
    logic [31:0] wb_d [4];

    dcache_responder dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    // Count serviced cycles just before each rising edge
    always begin
        @(negedge CLK);
        #4;
        if (!nRST) hit_seen = 0;
        else if (dhit) hit_seen++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue a request with a zero-wait memory and report the cycle index of its dhit
    task automatic req_hit(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] fill, output int cyc);
        @(negedge CLK);
        dmemWEN = we; dmemREN = !we; dmemaddr = addr; dmemstore = wdata;
        dwait = 1'b0; dload = fill;
        cyc = -1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            if (dWEN) begin wb_addr = daddr; wb_data = dstore; end
            if (dhit) begin cyc = i; break; end
        end
    endtask

    initial begin
        nRST = 1'b0; dmemREN = 0; dmemWEN = 0; halt = 0; dwait = 1;
        dmemaddr = 0; dmemstore = 0; dload = 0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_dhit", 32'(dhit), 0);
        chk("rst_dREN", 32'(dREN), 0);
        chk("rst_dWEN", 32'(dWEN), 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dstore", dstore, 0);
        chk("rst_flushed", 32'(flushed), 0);
        chk("rst_dmemload", dmemload, 0);

        // Test 1: clean read miss with two wait cycles
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        dmemREN = 1; dmemaddr = 32'h40; dwait = 1; dload = 32'hDEADBEEF;
        #1 chk("t1_miss_dhit", 32'(dhit), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 2) dwait = 0;
            #1;
            chk("t1_dREN", 32'(dREN), 1);
            chk("t1_daddr", daddr, 32'h40);
            chk("t1_fetch_dhit", 32'(dhit), 0);
        end
        @(negedge CLK);
        #1;
        chk("t1_dREN_off", 32'(dREN), 0);
        chk("t1_dhit", 32'(dhit), 1);
        chk("t1_dmemload", dmemload, 32'hDEADBEEF);

        // Test 2: write hit then read back
        @(negedge CLK);
        dmemREN = 0; dmemWEN = 1; dmemstore = 32'h12345678;
        #1;
        chk("t2_wr_dhit", 32'(dhit), 1);
        chk("t2_wr_mem", 32'({dREN, dWEN}), 0);
        @(negedge CLK);
        dmemWEN = 0; dmemREN = 1;
        #1;
        chk("t2_rd_dhit", 32'(dhit), 1);
        chk("t2_rd_data", dmemload, 32'h12345678);
        chk("t2_rd_mem", 32'({dREN, dWEN}), 0);

        // Test 3: conflict miss evicts the dirty line
        @(negedge CLK);
        dmemaddr = 32'h80; dwait = 0; dload = 32'hCAFE0080;
        #1 chk("t3_miss_dhit", 32'(dhit), 0);
        @(negedge CLK);
        #1;
        chk("t3_wb_dWEN", 32'(dWEN), 1);
        chk("t3_wb_dREN", 32'(dREN), 0);
        chk("t3_wb_daddr", daddr, 32'h40);
        chk("t3_wb_dstore", dstore, 32'h12345678);
        @(negedge CLK);
        #1;
        chk("t3_fetch_dREN", 32'(dREN), 1);
        chk("t3_fetch_dWEN", 32'(dWEN), 0);
        chk("t3_fetch_daddr", daddr, 32'h80);
        @(negedge CLK);
        #1;
        chk("t3_dhit", 32'(dhit), 1);
        chk("t3_dmemload", dmemload, 32'hCAFE0080);

        // Test 6: three consecutive hits, one per cycle
        @(negedge CLK);
        #1;
        chk("t6_h1_dhit", 32'(dhit), 1);
        chk("t6_h1_data", dmemload, 32'hCAFE0080);
        chk("t6_h1_mem", 32'({dREN, dWEN}), 0);
        @(negedge CLK);
        dmemREN = 0; dmemWEN = 1; dmemstore = 32'hA5A5A5A5;
        #1;
        chk("t6_h2_dhit", 32'(dhit), 1);
        chk("t6_h2_mem", 32'({dREN, dWEN}), 0);
        @(negedge CLK);
        dmemWEN = 0; dmemREN = 1;
        #1;
        chk("t6_h3_dhit", 32'(dhit), 1);
        chk("t6_h3_data", dmemload, 32'hA5A5A5A5);
        chk("t6_h3_mem", 32'({dREN, dWEN}), 0);

        // Test 4 setup: write-allocate misses leave 0x40 and 0x84 dirty
        wb_addr = 0; wb_data = 0;
        req_hit(1'b1, 32'h40, 32'h11111111, 32'h0BAD0040, ncyc);
        chk("t4_dirty_miss_cycles", 32'(ncyc), 3);
        chk("t4_evict_addr", wb_addr, 32'h80);
        chk("t4_evict_data", wb_data, 32'hA5A5A5A5);
        req_hit(1'b1, 32'h84, 32'h22222222, 32'h0BAD0084, ncyc);
        chk("t4_clean_miss_cycles", 32'(ncyc), 2);

        // Test 4: halt beats a same-cycle hit, then flush
        @(negedge CLK);
        halt = 1; dmemWEN = 0; dmemREN = 1; dmemaddr = 32'h40; dwait = 0;
        #1 chk("t4_halt_dhit", 32'(dhit), 0);
        nwb = 0; dren_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            #1;
            if (dREN) dren_seen++;
            if (dWEN) begin
                if (nwb < 4) begin wb_a[nwb] = daddr; wb_d[nwb] = dstore; end
                nwb++;
            end
            if (flushed) break;
        end
        chk("t4_flushed", 32'(flushed), 1);
        chk("t4_dren_seen", 32'(dren_seen), 0);
        chk("t4_wb0_addr", wb_a[0], 32'h40);
        chk("t4_wb0_data", wb_d[0], 32'h11111111);
        chk("t4_wb1_addr", wb_a[1], 32'h84);
        chk("t4_wb1_data", wb_d[1], 32'h22222222);
`ifdef HIT_COUNTER_EN
        chk("t4_nwb", 32'(nwb), 3);
        chk("t4_cnt_addr", wb_a[2], 32'h3100);
        chk("t4_cnt_data", wb_d[2], 32'(hit_seen));
`else
        chk("t4_nwb", 32'(nwb), 2);
`endif
        halt = 0; dmemaddr = 32'h84;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            chk("t4_sticky_flushed", 32'(flushed), 1);
            chk("t4_done_dhit", 32'(dhit), 0);
            chk("t4_done_mem", 32'({dREN, dWEN}), 0);
        end

        // Test 5: reset in the middle of a writeback
        @(negedge CLK);
        nRST = 0; dmemREN = 0;
        @(negedge CLK);
        nRST = 1;
        req_hit(1'b1, 32'h40, 32'h33333333, 32'h0, ncyc);
        chk("t5_fill_cycles", 32'(ncyc), 2);
        @(negedge CLK);
        dmemWEN = 0; dmemREN = 1; dmemaddr = 32'h80; dwait = 1;
        #1 chk("t5_miss_dhit", 32'(dhit), 0);
        @(negedge CLK);
        #1;
        chk("t5_wb_dWEN", 32'(dWEN), 1);
        chk("t5_wb_daddr", daddr, 32'h40);
        #1 nRST = 0;
        #1;
        chk("t5_rst_dWEN", 32'(dWEN), 0);
        chk("t5_rst_dREN", 32'(dREN), 0);
        chk("t5_rst_daddr", daddr, 0);
        chk("t5_rst_dstore", dstore, 0);
        chk("t5_rst_dhit", 32'(dhit), 0);
        chk("t5_rst_flushed", 32'(flushed), 0);
        @(negedge CLK);
        nRST = 1; dmemaddr = 32'h40; dwait = 0;
        #1 chk("t5_post_miss", 32'(dhit), 0);
        @(negedge CLK);
        #1;
        chk("t5_post_dREN", 32'(dREN), 1);
        chk("t5_post_daddr", daddr, 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
